// File: rtl/data_route_ctrl.sv
// Route controller ahead of the 1x2 data bridge: decodes cached/uncached targets, counts
// outstanding transactions and only flips the bridge select once the old path has drained.
module data_route_ctrl #(
    parameter int unsigned MAX_OUTST = 4,
    parameter logic [31:0] UC_MASK   = 32'hE000_0000,
    parameter logic [31:0] UC_MATCH  = 32'hA000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic        br_data_req,
    output logic        br_data_wr,
    output logic [1:0]  br_data_size,
    output logic [31:0] br_data_addr,
    output logic [31:0] br_data_wdata,
    input  logic [31:0] br_data_rdata,
    input  logic        br_data_addr_ok,
    input  logic        br_data_data_ok,
    output logic        now_dcache,
    output logic        route_err
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] SWITCH = 1'b1;

    logic [0:0]    state;
    logic          cur_route;
    logic [CW-1:0] outst_cnt;
    logic [CW-1:0] cnt_nxt;
    logic          new_dc;
    logic          fwd;
    logic          accept;
    logic          resp;
    logic          spurious;
    logic          switch_go;

    assign new_dc = (cpu_data_addr & UC_MASK) != UC_MATCH;
    assign fwd    = !rst && (state == RUN) && cpu_data_req && (new_dc == cur_route)
                    && (outst_cnt < CW'(MAX_OUTST));

    assign br_data_req      = fwd;
    assign cpu_data_addr_ok = fwd & br_data_addr_ok;
    assign br_data_wr       = cpu_data_wr;
    assign br_data_size     = cpu_data_size;
    assign br_data_addr     = cpu_data_addr;
    assign br_data_wdata    = cpu_data_wdata;
    assign cpu_data_rdata   = br_data_rdata;
    assign cpu_data_data_ok = br_data_data_ok;
    assign now_dcache       = cur_route;

    assign accept   = br_data_req & br_data_addr_ok;
    assign resp     = br_data_data_ok;
    assign spurious = resp && (outst_cnt == '0);

    always_comb begin
        cnt_nxt = outst_cnt;
        if (accept && !resp)
            cnt_nxt = outst_cnt + 1'b1;
        else if (resp && !accept) begin
            if (outst_cnt != '0)
                cnt_nxt = outst_cnt - 1'b1;
        end else if (accept && spurious)
            // a stray response cannot retire the request accepted alongside it
            cnt_nxt = CW'(1);
    end

    // route flips only when nothing is owed after this cycle's response
    assign switch_go = (state == RUN) && cpu_data_req && (new_dc != cur_route) && (cnt_nxt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cur_route <= 1'b1;
            outst_cnt <= '0;
            route_err <= 1'b0;
        end else begin
            outst_cnt <= cnt_nxt;
            if (spurious)
                route_err <= 1'b1;
            case (state)
                RUN: begin
                    if (switch_go) begin
                        state     <= SWITCH;
                        cur_route <= new_dc;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_data_route_ctrl.sv
// Directed bench for data_route_ctrl: read data is scoreboarded through a queue, control
// outputs and route state are checked at fixed points in the sequence.
module tb_data_route_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_data_req;
    logic        cpu_data_wr;
    logic [1:0]  cpu_data_size;
    logic [31:0] cpu_data_addr;
    logic [31:0] cpu_data_wdata;
    logic [31:0] cpu_data_rdata;
    logic        cpu_data_addr_ok;
    logic        cpu_data_data_ok;
    logic        br_data_req;
    logic        br_data_wr;
    logic [1:0]  br_data_size;
    logic [31:0] br_data_addr;
    logic [31:0] br_data_wdata;
    logic [31:0] br_data_rdata;
    logic        br_data_addr_ok;
    logic        br_data_data_ok;
    logic        now_dcache;
    logic        route_err;

    data_route_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr), .cpu_data_size(cpu_data_size),
        .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata),
        .cpu_data_rdata(cpu_data_rdata), .cpu_data_addr_ok(cpu_data_addr_ok),
        .cpu_data_data_ok(cpu_data_data_ok),
        .br_data_req(br_data_req), .br_data_wr(br_data_wr), .br_data_size(br_data_size),
        .br_data_addr(br_data_addr), .br_data_wdata(br_data_wdata),
        .br_data_rdata(br_data_rdata), .br_data_addr_ok(br_data_addr_ok),
        .br_data_data_ok(br_data_data_ok),
        .now_dcache(now_dcache), .route_err(route_err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] br_q[$];
    logic [31:0] rd_seq = 32'h0000_1000;
    logic        bridge_aok = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; responses are popped before this cycle's accept is pushed.
    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic dok,
                        input logic exp_req, input logic exp_aok, input string tag);
        logic [31:0] exp_rd;
        exp_rd           = 32'hdead_beef;
        cpu_data_req     = r;
        cpu_data_wr      = w;
        cpu_data_size    = 2'd2;
        cpu_data_addr    = a;
        cpu_data_wdata   = a ^ 32'h5a5a_5a5a;
        br_data_addr_ok  = bridge_aok;
        br_data_data_ok  = dok;
        br_data_rdata    = 32'hdead_beef;
        if (dok && br_q.size() != 0) br_data_rdata = br_q.pop_front();
        if (dok && exp_q.size() != 0) exp_rd = exp_q.pop_front();
        if (r && exp_aok) begin
            exp_q.push_back(rd_seq);
            br_q.push_back(rd_seq);
            rd_seq++;
        end
        #2;
        chk({tag, ".br_req"}, {31'd0, br_data_req}, {31'd0, exp_req});
        chk({tag, ".addr_ok"}, {31'd0, cpu_data_addr_ok}, {31'd0, exp_aok});
        chk({tag, ".br_addr"}, br_data_addr, a);
        chk({tag, ".br_wdata"}, br_data_wdata, a ^ 32'h5a5a_5a5a);
        chk({tag, ".br_wr_size"}, {29'd0, br_data_wr, br_data_size}, {29'd0, w, 2'd2});
        chk({tag, ".data_ok"}, {31'd0, cpu_data_data_ok}, {31'd0, dok});
        if (dok) chk({tag, ".rdata"}, cpu_data_rdata, exp_rd);
    endtask

    initial begin
        rst = 1'b1;
        cpu_data_req = 1'b0; cpu_data_wr = 1'b0; cpu_data_size = 2'd2;
        cpu_data_addr = '0; cpu_data_wdata = '0;
        br_data_rdata = '0; br_data_addr_ok = 1'b1; br_data_data_ok = 1'b0;
        tick();
        // request held high during reset must not reach the bridge
        step(1, 0, 32'h8000_0000, 0, 0, 0, "rst");
        chk("rst.now_dc", {31'd0, now_dcache}, 32'd1);
        chk("rst.err", {31'd0, route_err}, 32'd0);
        tick();
        rst = 1'b0;

        // three cached reads, each answered two cycles later
        step(1, 0, 32'h8000_0000, 0, 1, 1, "t1a"); tick();
        step(1, 0, 32'h8000_0004, 0, 1, 1, "t1b"); tick();
        step(1, 0, 32'h8000_0008, 1, 1, 1, "t1c"); tick();
        step(0, 0, 32'h0000_0000, 1, 0, 0, "t1d"); tick();
        step(0, 0, 32'h0000_0000, 1, 0, 0, "t1e"); tick();
        chk("t1.now_dc", {31'd0, now_dcache}, 32'd1);
        chk("t1.err", {31'd0, route_err}, 32'd0);

        // uncached write waits for the cached read to drain, then one bubble
        step(1, 0, 32'h8000_0010, 0, 1, 1, "t2a"); tick();
        step(1, 1, 32'hBFAF_F000, 0, 0, 0, "t2hold"); tick();
        chk("t2hold.now_dc", {31'd0, now_dcache}, 32'd1);
        step(1, 1, 32'hBFAF_F000, 1, 0, 0, "t2dec"); tick();
        chk("t2dec.now_dc", {31'd0, now_dcache}, 32'd0);
        step(1, 1, 32'hBFAF_F000, 0, 0, 0, "t2sw"); tick();
        step(1, 1, 32'hBFAF_F000, 0, 1, 1, "t2fwd"); tick();
        step(0, 0, 32'h0000_0000, 1, 0, 0, "t2rsp"); tick();
        chk("t2.now_dc", {31'd0, now_dcache}, 32'd0);

        // back to cached, then fill to MAX_OUTST
        step(1, 0, 32'h8000_0100, 0, 0, 0, "t3dec"); tick();
        chk("t3dec.now_dc", {31'd0, now_dcache}, 32'd1);
        step(1, 0, 32'h8000_0100, 0, 0, 0, "t3sw"); tick();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 32'h8000_0100 + 32'(4 * i), 0, 1, 1, "t3acc"); tick();
        end
        step(1, 0, 32'h8000_0110, 0, 0, 0, "t3full"); tick();
        step(1, 0, 32'h8000_0110, 1, 0, 0, "t3full_rsp"); tick();
        step(1, 0, 32'h8000_0110, 0, 1, 1, "t3fifth"); tick();
        step(1, 0, 32'h8000_0114, 0, 0, 0, "t3still_full"); tick();

        // drain to two, then accept+response in one cycle keeps the count at two
        step(0, 0, 32'h0000_0000, 1, 0, 0, "t4drain"); tick();
        step(0, 0, 32'h0000_0000, 1, 0, 0, "t4drain"); tick();
        step(1, 0, 32'h8000_0200, 1, 1, 1, "t4both"); tick();
        step(1, 0, 32'h8000_0204, 0, 1, 1, "t4acc3"); tick();
        step(1, 0, 32'h8000_0208, 0, 1, 1, "t4acc4"); tick();
        step(1, 0, 32'h8000_020c, 0, 0, 0, "t4blk"); tick();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0000_0000, 1, 0, 0, "t4drain"); tick();
        end

        // bridge not accepting: request forwarded but not acknowledged
        bridge_aok = 1'b0;
        step(1, 0, 32'h8000_0300, 0, 1, 0, "aok0"); tick();
        bridge_aok = 1'b1;

        // spurious response sets the sticky error and leaves the count at zero
        step(0, 0, 32'h0000_0000, 1, 0, 0, "t5spur"); tick();
        chk("t5.err", {31'd0, route_err}, 32'd1);
        step(1, 0, 32'hA000_0000, 0, 0, 0, "t5dec"); tick();
        chk("t5dec.now_dc", {31'd0, now_dcache}, 32'd0);
        step(1, 0, 32'hA000_0000, 0, 0, 0, "t5sw"); tick();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 32'hA000_0000 + 32'(4 * i), 0, 1, 1, "t5acc"); tick();
        end
        chk("t5.err_sticky", {31'd0, route_err}, 32'd1);

        // reset with three uncached transactions in flight
        rst = 1'b1;
        step(1, 0, 32'hA000_0010, 0, 0, 0, "t6rst"); tick();
        rst = 1'b0;
        chk("t6.now_dc", {31'd0, now_dcache}, 32'd1);
        chk("t6.err", {31'd0, route_err}, 32'd0);
        step(0, 0, 32'h0000_0000, 0, 0, 0, "t6idle"); tick();
        step(0, 0, 32'h0000_0000, 1, 0, 0, "t6late"); tick();
        chk("t6late.err", {31'd0, route_err}, 32'd1);
        step(1, 0, 32'hA000_0020, 0, 0, 0, "t6dec"); tick();
        chk("t6dec.now_dc", {31'd0, now_dcache}, 32'd0);
        step(0, 0, 32'h0000_0000, 1, 0, 0, "t6late2"); tick();
        step(0, 0, 32'h0000_0000, 1, 0, 0, "t6late3"); tick();
        chk("t6.q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
